// File: rtl/edge_pkg.sv
// Shared constants for the packed 1-bit edge bitmap: word width, bit order and pixel polarity.
// The Sobel-side packer imports the same package, so both ends agree on the bitmap format.
package edge_pkg;

    localparam int WORD_W = 16;
    localparam int RGB_W  = 16;

    localparam logic [RGB_W-1:0] ONE_COLOR  = 16'hFFFF;
    localparam logic [RGB_W-1:0] ZERO_COLOR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_PENDING,
        FETCH_FULL
    } fetch_state_e;

    function automatic logic [RGB_W-1:0] pick_color(
        input logic             b,
        input logic [RGB_W-1:0] one_c,
        input logic [RGB_W-1:0] zero_c
    );
        return b ? one_c : zero_c;
    endfunction

endpackage

// File: rtl/edge_bitmap_unpack.sv
// Expands packed edge-bitmap words from the SDRAM read FIFO into one RGB565 pixel per request,
// MSB first, with a one-word prefetch so word boundaries cost no bubble.
module edge_bitmap_unpack #(
    parameter int                          WORD_W     = edge_pkg::WORD_W,
    parameter logic [edge_pkg::RGB_W-1:0]  ONE_COLOR  = edge_pkg::ONE_COLOR,
    parameter logic [edge_pkg::RGB_W-1:0]  ZERO_COLOR = edge_pkg::ZERO_COLOR
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          frame_start,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic [WORD_W-1:0]             fifo_rd_data,
    input  logic                          pix_req,
    output logic [edge_pkg::RGB_W-1:0]    pix_data,
    output logic                          pix_valid,
    output logic                          underflow
);
    import edge_pkg::*;

    localparam int               CNT_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] cur_word_reg;
    logic [WORD_W-1:0] nxt_word_reg;
    logic [CNT_W-1:0]  cur_cnt_reg;
    logic              nxt_valid_reg;
    logic              rd_pending_reg;
    logic              drop_reg;
    fetch_state_e      fetch_state;

    // Fetch control: a full prefetch slot wins over a pop still in flight.
    always_comb begin
        fetch_state = FETCH_IDLE;
        if (nxt_valid_reg) begin
            fetch_state = FETCH_FULL;
        end else if (rd_pending_reg) begin
            fetch_state = FETCH_PENDING;
        end
    end

    assign fifo_rd_en = !sys_rst && (fetch_state == FETCH_IDLE) && !fifo_empty && !frame_start;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_word_reg   <= '0;
            nxt_word_reg   <= '0;
            cur_cnt_reg    <= '0;
            nxt_valid_reg  <= 1'b0;
            rd_pending_reg <= 1'b0;
            drop_reg       <= 1'b0;
            pix_data       <= '0;
            pix_valid      <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            rd_pending_reg <= fifo_rd_en;
            drop_reg       <= frame_start && rd_pending_reg;
            pix_valid      <= pix_req && !frame_start;

            if (frame_start) begin
                cur_cnt_reg   <= '0;
                nxt_valid_reg <= 1'b0;
                underflow     <= 1'b0;
            end else begin
                // A landing word only fills the prefetch slot; it is never emitted the same cycle.
                if (rd_pending_reg && !drop_reg) begin
                    nxt_word_reg  <= fifo_rd_data;
                    nxt_valid_reg <= 1'b1;
                end

                if (pix_req) begin
                    if (cur_cnt_reg != '0) begin
                        pix_data     <= pick_color(cur_word_reg[WORD_W-1], ONE_COLOR, ZERO_COLOR);
                        cur_word_reg <= cur_word_reg << 1;
                        cur_cnt_reg  <= cur_cnt_reg - CNT_W'(1);
                    end else if (nxt_valid_reg) begin
                        pix_data      <= pick_color(nxt_word_reg[WORD_W-1], ONE_COLOR, ZERO_COLOR);
                        cur_word_reg  <= nxt_word_reg << 1;
                        cur_cnt_reg   <= CNT_RELOAD;
                        nxt_valid_reg <= 1'b0;
                    end else begin
                        pix_data  <= ONE_COLOR;
                        underflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
